mem_interface: RTL and testbench

Memory interface unit between the CPU datapath/control unit and the 512 x 32 synchronous RAM. Holds the Memory Address Register (MAR) and Memory Data Register (MDR), and runs a read/write request-done handshake toward the control unit. Generates the RAM's `Read`, `Write`, `Address` and `Mdatain` strobes, and absorbs the RAM's one-cycle registered read latency plus an optional number of wait states.

---
 rtl/mem_interface_if.sv | 33 +++
 rtl/mem_interface.sv | 89 ++++++++
 tb/tb_mem_interface.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_interface_if.sv
// Bus bundle between the control unit, the memory interface unit and the RAM.
// slave is the memory interface unit; master is the side driving the CPU bus and RAM data.
interface mem_interface_if #(
  parameter int AW = 9,
  parameter int DW = 32
);
  logic [DW-1:0] BusMuxOut;
  logic          MARin;
  logic          MDRin;
  logic          Read_req;
  logic          Write_req;
  logic [AW-1:0] MAR_out;
  logic [DW-1:0] MDR_out;
  logic          Mem_busy;
  logic          Mem_done;
  logic          ram_Read;
  logic          ram_Write;
  logic [AW-1:0] ram_Address;
  logic [DW-1:0] ram_Mdatain;
  logic [DW-1:0] ram_data;

  modport slave (
    input  BusMuxOut, MARin, MDRin, Read_req, Write_req, ram_data,
    output MAR_out, MDR_out, Mem_busy, Mem_done,
           ram_Read, ram_Write, ram_Address, ram_Mdatain
  );

  modport master (
    output BusMuxOut, MARin, MDRin, Read_req, Write_req, ram_data,
    input  MAR_out, MDR_out, Mem_busy, Mem_done,
           ram_Read, ram_Write, ram_Address, ram_Mdatain
  );
endinterface

// File: rtl/mem_interface.sv
// Memory interface unit: MAR/MDR plus a request/done handshake to a synchronous RAM
// with one-cycle registered read data and READ_WAIT optional wait states.
//
// state    | meaning
// IDLE     | accepts MAR/MDR loads and samples Read_req/Write_req (write wins)
// RD_ISSUE | ram_Read high for one cycle; wait counter loaded
// RD_WAIT  | READ_WAIT extra cycles before capture
// RD_CAP   | MDR captures ram_data at the closing edge
// WR_ISSUE | ram_Write high for one cycle; RAM writes MDR to MAR
// DONE     | Mem_done pulse, back to IDLE
module mem_interface #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int READ_WAIT  = 0
) (
  input logic            Clock,
  input logic            Clear_n,
  mem_interface_if.slave mif
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    RD_CAP,
    WR_ISSUE,
    DONE
  } state_t;

  state_t                state, state_nx;
  logic [3:0]            wcnt, wcnt_nx;
  logic [ADDR_WIDTH-1:0] mar, mar_nx;
  logic [DATA_WIDTH-1:0] mdr, mdr_nx;

  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) begin
      state <= IDLE;
      wcnt  <= '0;
      mar   <= '0;
      mdr   <= '0;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
      mar   <= mar_nx;
      mdr   <= mdr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    mar_nx   = mar;
    mdr_nx   = mdr;
    case (state)
      IDLE: begin
        if (mif.MARin) mar_nx = mif.BusMuxOut[ADDR_WIDTH-1:0];
        if (mif.MDRin) mdr_nx = mif.BusMuxOut;
        if (mif.Write_req)     state_nx = WR_ISSUE;
        else if (mif.Read_req) state_nx = RD_ISSUE;
      end
      RD_ISSUE: begin
        wcnt_nx  = 4'(READ_WAIT);
        state_nx = (READ_WAIT > 0) ? RD_WAIT : RD_CAP;
      end
      RD_WAIT: begin
        wcnt_nx = wcnt - 4'd1;
        // <= rather than == so a corrupted zero count cannot strand the FSM
        if (wcnt <= 4'd1) state_nx = RD_CAP;
      end
      RD_CAP: begin
        mdr_nx   = mif.ram_data;
        state_nx = DONE;
      end
      WR_ISSUE: state_nx = DONE;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  assign mif.MAR_out     = mar;
  assign mif.MDR_out     = mdr;
  assign mif.ram_Address = mar;
  assign mif.ram_Mdatain = mdr;
  assign mif.Mem_busy    = (state != IDLE);
  assign mif.Mem_done    = (state == DONE);
  assign mif.ram_Read    = (state == RD_ISSUE);
  assign mif.ram_Write   = (state == WR_ISSUE);

endmodule

// File: tb/tb_mem_interface.sv
// Bench for mem_interface: two instances (READ_WAIT 0 and 2) driven with the same
// stimulus, each against its own RAM model, checked against a transaction-level model.
module tb_mem_interface;
  localparam int AW  = 9;
  localparam int DW  = 32;
  localparam int RW0 = 0;
  localparam int RW1 = 2;

  logic Clock = 1'b0;
  logic Clear_n = 1'b0;
  always #5 Clock = ~Clock;

  logic [DW-1:0] bus = '0;
  logic marin = 1'b0, mdrin = 1'b0, rreq = 1'b0, wreq = 1'b0;
  logic load_ram = 1'b1;

  mem_interface_if #(.AW(AW), .DW(DW)) if0 ();
  mem_interface_if #(.AW(AW), .DW(DW)) if1 ();

  assign if0.BusMuxOut = bus;   assign if1.BusMuxOut = bus;
  assign if0.MARin     = marin; assign if1.MARin     = marin;
  assign if0.MDRin     = mdrin; assign if1.MDRin     = mdrin;
  assign if0.Read_req  = rreq;  assign if1.Read_req  = rreq;
  assign if0.Write_req = wreq;  assign if1.Write_req = wreq;

  mem_interface #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_WAIT(RW0)) dut0 (
    .Clock(Clock), .Clear_n(Clear_n), .mif(if0.slave));
  mem_interface #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_WAIT(RW1)) dut1 (
    .Clock(Clock), .Clear_n(Clear_n), .mif(if1.slave));

  // RAM models: registered read, synchronous write, bulk preload from the reference image
  logic [DW-1:0] ref_mem [512];
  logic [DW-1:0] mem0 [512];
  logic [DW-1:0] mem1 [512];
  logic [DW-1:0] rdata0, rdata1;
  assign if0.ram_data = rdata0;
  assign if1.ram_data = rdata1;

  always @(posedge Clock) begin
    if (load_ram) begin
      for (int k = 0; k < 512; k++) begin
        mem0[k] <= ref_mem[k];
        mem1[k] <= ref_mem[k];
      end
    end else begin
      if (if0.ram_Write) mem0[if0.ram_Address] <= if0.ram_Mdatain;
      if (if1.ram_Write) mem1[if1.ram_Address] <= if1.ram_Mdatain;
    end
    if (if0.ram_Read) rdata0 <= mem0[if0.ram_Address];
    if (if1.ram_Read) rdata1 <= mem1[if1.ram_Address];
  end

  logic [1:0]    o_rd, o_wr, o_done, o_busy;
  logic [AW-1:0] o_mar [2];
  logic [AW-1:0] o_addr [2];
  logic [DW-1:0] o_mdr [2];
  logic [DW-1:0] o_mdat [2];
  assign o_rd   = {if1.ram_Read,  if0.ram_Read};
  assign o_wr   = {if1.ram_Write, if0.ram_Write};
  assign o_done = {if1.Mem_done,  if0.Mem_done};
  assign o_busy = {if1.Mem_busy,  if0.Mem_busy};
  assign o_mar[0]  = if0.MAR_out;     assign o_mar[1]  = if1.MAR_out;
  assign o_addr[0] = if0.ram_Address; assign o_addr[1] = if1.ram_Address;
  assign o_mdr[0]  = if0.MDR_out;     assign o_mdr[1]  = if1.MDR_out;
  assign o_mdat[0] = if0.ram_Mdatain; assign o_mdat[1] = if1.ram_Mdatain;

  int n_checks = 0;
  int n_errors = 0;
  logic [AW-1:0] ref_mar;
  logic [DW-1:0] ref_mdr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_ctl"}, {o_mar[i], o_busy[i], o_done[i], o_rd[i], o_wr[i], o_addr[i]}, 64'd0);
      chk({tag, "_data"}, {o_mdr[i], o_mdat[i]}, 64'd0);
    end
  endtask

  task automatic drive_idle_inputs();
    bus = '0; marin = 1'b0; mdrin = 1'b0; rreq = 1'b0; wreq = 1'b0;
  endtask

  // One IDLE cycle of register loads with no request.
  task automatic load_regs(input bit ld_mar, input bit ld_mdr, input logic [DW-1:0] bv);
    bus = bv; marin = ld_mar; mdrin = ld_mdr; rreq = 1'b0; wreq = 1'b0;
    if (ld_mar) ref_mar = bv[AW-1:0];
    if (ld_mdr) ref_mdr = bv;
    step();
    drive_idle_inputs();
  endtask

  // Full transaction issued from IDLE; loads may share the request cycle.
  // Random loads and requests are thrown at the busy units for two cycles.
  task automatic do_txn(input bit is_wr, input bit both, input bit ld_mar,
                        input bit ld_mdr, input logic [DW-1:0] bv);
    int lat [2];
    int done_c [2];
    int nd [2];
    int nwr [2];
    int nrd [2];
    int last;
    logic [DW-1:0] exp_mdr;
    bus = bv; marin = ld_mar; mdrin = ld_mdr;
    wreq = is_wr; rreq = !is_wr || both;
    if (ld_mar) ref_mar = bv[AW-1:0];
    if (ld_mdr) ref_mdr = bv;
    if (is_wr) ref_mem[ref_mar] = ref_mdr;
    exp_mdr = is_wr ? ref_mdr : ref_mem[ref_mar];
    lat[0] = is_wr ? 2 : RW0 + 3;
    lat[1] = is_wr ? 2 : RW1 + 3;
    last = (lat[0] > lat[1]) ? lat[0] : lat[1];
    for (int i = 0; i < 2; i++) begin
      done_c[i] = -1; nd[i] = 0; nwr[i] = 0; nrd[i] = 0;
    end
    for (int c = 1; c <= last + 1; c++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("busy%0d_c%0d", i, c), 64'(o_busy[i]), 64'(c <= lat[i]));
        chk($sformatf("excl%0d", i), 64'(o_rd[i] & o_wr[i]), 64'd0);
        if (o_wr[i]) begin
          nwr[i]++;
          chk($sformatf("wr_addr%0d", i), 64'(o_addr[i]), 64'(ref_mar));
          chk($sformatf("wr_data%0d", i), 64'(o_mdat[i]), 64'(ref_mdr));
        end
        if (o_rd[i]) begin
          nrd[i]++;
          chk($sformatf("rd_addr%0d", i), 64'(o_addr[i]), 64'(ref_mar));
        end
        if (o_done[i]) begin
          nd[i]++;
          done_c[i] = c;
          chk($sformatf("done_mdr%0d", i), 64'(o_mdr[i]), 64'(exp_mdr));
        end
      end
      if (c <= 2) begin
        bus   = $urandom;
        marin = 1'($urandom_range(0, 1));
        mdrin = 1'($urandom_range(0, 1));
        rreq  = 1'($urandom_range(0, 1));
        wreq  = 1'($urandom_range(0, 1));
      end else begin
        drive_idle_inputs();
      end
    end
    ref_mdr = exp_mdr;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("latency%0d", i), 64'(done_c[i]), 64'(lat[i]));
      chk($sformatf("ndone%0d", i), 64'(nd[i]), 64'd1);
      chk($sformatf("nwrite%0d", i), 64'(nwr[i]), 64'(is_wr));
      chk($sformatf("nread%0d", i), 64'(nrd[i]), 64'(!is_wr));
      chk($sformatf("mar_end%0d", i), 64'(o_mar[i]), 64'(ref_mar));
      chk($sformatf("mdr_end%0d", i), 64'(o_mdr[i]), 64'(ref_mdr));
    end
  endtask

  task automatic reset_abort_write();
    logic [AW-1:0] a;
    logic [DW-1:0] v;
    a = AW'($urandom_range(1, 511));
    v = ~ref_mem[a];
    load_regs(1'b1, 1'b0, DW'(a));
    bus = v; mdrin = 1'b1; wreq = 1'b1;
    step();
    drive_idle_inputs();
    chk("abort_wr_strobe", 64'(o_wr), 64'd3);
    #3 Clear_n = 1'b0;
    #1 chk_all_zero("abort_async");
    for (int c = 0; c < 3; c++) begin
      step();
      chk("abort_no_done", 64'(o_done), 64'd0);
    end
    Clear_n = 1'b1;
    ref_mar = '0;
    ref_mdr = '0;
    chk("abort_mem0", 64'(mem0[a]), 64'(ref_mem[a]));
    chk("abort_mem1", 64'(mem1[a]), 64'(ref_mem[a]));
    chk_all_zero("abort_after");
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 512; k++) ref_mem[k] = $urandom;
    ref_mem[9'h054] = 32'h0000_0097;
    ref_mar = '0;
    ref_mdr = '0;
    #2 chk_all_zero("reset");
    repeat (3) @(posedge Clock);
    #1;
    load_ram = 1'b0;
    Clear_n  = 1'b1;
    step();

    // read straight out of reset with MAR=0
    do_txn(1'b0, 1'b0, 1'b0, 1'b0, '0);

    // write 0x1A0 then read back after clearing MDR
    load_regs(1'b1, 1'b0, 32'h0000_01A0);
    do_txn(1'b1, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    load_regs(1'b0, 1'b1, 32'h0);
    do_txn(1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("readback", 64'(o_mdr[1]), 64'h0000_0000_DEAD_BEEF);

    // preloaded location, MAR loaded together with the request
    do_txn(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0054);
    chk("preload", 64'(o_mdr[1]), 64'h97);

    // simultaneous read and write requests
    do_txn(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0033);

    reset_abort_write();
    do_txn(1'b0, 1'b0, 1'b0, 1'b0, '0);

    for (int t = 0; t < 60; t++) begin
      logic [DW-1:0] bv;
      bit wr;
      bv = $urandom;
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) load_regs(1'b1, 1'b0, $urandom);
      do_txn(wr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             wr ? 1'($urandom_range(0, 1)) : 1'b0, bv);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
